fir4dec: RTL and testbench



---
 rtl/fir4_pkg.sv | 25 ++
 rtl/fir4dec_if.sv | 20 ++
 rtl/fir4dec_hist.sv | 43 ++++
 rtl/fir4dec.sv | 118 +++++++++++
 tb/tb_fir4dec.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir4_pkg.sv
// fir4_pkg: definitions shared by the 4-tap moving-sum filter and its
// reconstruction block (fir4dec).
//   W           sample width; 4-sample sums are W+2 bits wide
//   sample_t    one w-bit sample
//   sum_t       one (w+2)-bit 4-sample sum / reconstruction accumulator
//   dec_state_e reconstruction state (ERR only reachable in the checked build)
package fir4_pkg;

  localparam int W = 16;

  typedef logic [W-1:0] sample_t;
  typedef logic [W+1:0] sum_t;

  typedef enum logic {
    RUN = 1'b0,
    ERR = 1'b1
  } dec_state_e;

  // A reconstructed value must fit in w bits; the two guard bits flag an
  // upstream sum that no valid w-bit sample stream could have produced.
  function automatic logic range_bad(input sum_t x);
    return x[W+1:W] != 2'b00;
  endfunction

endpackage

// File: rtl/fir4dec_if.sv
// fir4dec_if: one valid/ready stream.
//   data   payload, WIDTH bits
//   valid  producer has a payload on data
//   ready  consumer can take it
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// Once valid is high the producer keeps valid and data stable until that
// transfer; ready may change freely and may depend combinationally on the
// consumer's own downstream ready, never on valid.
interface fir4dec_if #(
  parameter int WIDTH = 16
) ();

  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/fir4dec_hist.sv
// fir4dec_hist: 4-deep history of reconstructed values.
//   clk, reset  clock, synchronous active-high reset
//   clear       zero all entries (a same-cycle shift still loads d into entry 0)
//   shift_en    push d into entry 0, everything moves one place older
//   d           new value
//   oldest      entry 3, the value pushed four shifts ago
module fir4dec_hist
  import fir4_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic shift_en,
  input  sum_t d,
  output sum_t oldest
);

  sum_t h0, h1, h2, h3;

  always_ff @(posedge clk) begin
    if (reset) begin
      h0 <= '0;
      h1 <= '0;
      h2 <= '0;
      h3 <= '0;
    end else if (clear) begin
      // The caller already computed d against zeroed history, so d is the
      // first entry of the fresh history.
      h0 <= shift_en ? d : '0;
      h1 <= '0;
      h2 <= '0;
      h3 <= '0;
    end else if (shift_en) begin
      h0 <= d;
      h1 <= h0;
      h2 <= h1;
      h3 <= h2;
    end
  end

  assign oldest = h3;

endmodule

// File: rtl/fir4dec.sv
// fir4dec: undoes the 4-tap moving sum, x[n] = s[n] - s[n-1] + x[n-4]
// (mod 2^(w+2)), presenting x[w-1:0] one cycle after each accepted sum.
//   clk, reset  clock, synchronous active-high reset
//   clear       history flush (s_prev and hist zeroed; output and err untouched)
//   s_if        slave stream of (w+2)-bit sums
//   a_if        master stream of w-bit reconstructed samples
//   err         sticky range error (0 unless FIR4DEC_CHECK_EN)
//   err_cnt     saturating range-error count (0 unless FIR4DEC_CHECK_EN)
//   state_dbg   current reconstruction state
// Build option: define FIR4DEC_CHECK_EN to enable the range check/ERR state.
module fir4dec
  import fir4_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  fir4dec_if.slave         s_if,
  fir4dec_if.master        a_if,
  output logic             err,
  output logic [7:0]       err_cnt,
  output dec_state_e       state_dbg
);

  sum_t    s_prev_q;
  sum_t    s_prev_eff;
  sum_t    hist_old;
  sum_t    hist_eff;
  sum_t    x;
  sample_t a_out_q;
  logic    a_valid_q;
  logic    accept;

  // Single output stage: free whenever it is empty or draining this cycle.
  assign s_if.ready = !a_valid_q || a_if.ready;
  assign accept     = s_if.valid && s_if.ready;

  // A clear in the same cycle as an accept means this sum starts a new stream.
  always_comb begin
    s_prev_eff = clear ? '0 : s_prev_q;
    hist_eff   = clear ? '0 : hist_old;
    x          = s_if.data - s_prev_eff + hist_eff;
  end

  fir4dec_hist u_hist (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .shift_en (accept),
    .d        (x),
    .oldest   (hist_old)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      s_prev_q <= '0;
    end else if (accept) begin
      s_prev_q <= s_if.data;
    end else if (clear) begin
      s_prev_q <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_out_q   <= '0;
      a_valid_q <= 1'b0;
    end else if (accept) begin
      a_out_q   <= x[W-1:0];
      a_valid_q <= 1'b1;
    end else if (a_if.ready) begin
      a_valid_q <= 1'b0;
    end
  end

  assign a_if.data  = a_out_q;
  assign a_if.valid = a_valid_q;

`ifdef FIR4DEC_CHECK_EN
  dec_state_e state_q;
  dec_state_e state_d;
  logic       range_err;
  logic [7:0] err_cnt_q;

  assign range_err = accept && range_bad(x);

  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // ERR is terminal until reset; reconstruction carries on regardless.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (range_err) state_d = ERR;
      ERR:     state_d = ERR;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt_q <= '0;
    end else if (range_err && err_cnt_q != 8'hFF) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err       = (state_q == ERR);
  assign err_cnt   = err_cnt_q;
  assign state_dbg = state_q;
`else
  assign err       = 1'b0;
  assign err_cnt   = 8'd0;
  assign state_dbg = RUN;
`endif

endmodule

// File: tb/tb_fir4dec.sv
module tb_fir4dec;
  import fir4_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic       err;
  logic [7:0] err_cnt;
  dec_state_e state_dbg;

  fir4dec_if #(.WIDTH(W + 2)) s_if ();
  fir4dec_if #(.WIDTH(W))     a_if ();

  fir4dec dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .s_if      (s_if),
    .a_if      (a_if),
    .err       (err),
    .err_cnt   (err_cnt),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

`ifdef FIR4DEC_CHECK_EN
  localparam bit CHECK_BUILD = 1'b1;
`else
  localparam bit CHECK_BUILD = 1'b0;
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Inputs change at the falling edge; outputs are read 1 time unit later,
  // i.e. they reflect the previous rising edge and the inputs just applied.
  task automatic drive_cycle(input logic v, input sum_t d, input logic r, input logic c);
    @(negedge clk);
    s_if.valid = v;
    s_if.data  = d;
    a_if.ready = r;
    clear      = c;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset      = 1'b1;
    clear      = 1'b0;
    s_if.valid = 1'b0;
    s_if.data  = '0;
    a_if.ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (a_if.valid !== 1'b0) begin errors++; $display("FAIL reset_a_valid: got %b expected 0", a_if.valid); end
    checks++; if (a_if.data !== '0) begin errors++; $display("FAIL reset_a_out: got %h expected 0", a_if.data); end
    checks++; if (s_if.ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b expected 1", s_if.ready); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
    checks++; if (state_dbg !== RUN) begin errors++; $display("FAIL reset_state: got %0d expected RUN", state_dbg); end
  endtask

  task automatic test_basic(input string tag);
    sum_t s[5];
    s = '{18'd1, 18'd3, 18'd6, 18'd10, 18'd14};
    for (int i = 0; i <= 5; i++) begin
      if (i < 5) drive_cycle(1'b1, s[i], 1'b1, 1'b0);
      else       drive_cycle(1'b0, '0, 1'b1, 1'b0);
      if (i < 5) begin
        checks++;
        if (s_if.ready !== 1'b1) begin errors++; $display("FAIL %s_s_ready[%0d]: got %b expected 1", tag, i, s_if.ready); end
      end
      checks++;
      if (i == 0) begin
        if (a_if.valid !== 1'b0) begin errors++; $display("FAIL %s_latency: got a_valid=%b expected 0", tag, a_if.valid); end
      end else begin
        if (a_if.valid !== 1'b1 || a_if.data !== sample_t'(i)) begin
          errors++; $display("FAIL %s_out[%0d]: got v=%b %h expected v=1 %h", tag, i, a_if.valid, a_if.data, sample_t'(i));
        end
      end
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL %s_err[%0d]: got %b expected 0", tag, i, err); end
    end
  endtask

  task automatic test_wrap();
    sum_t s[6];
    do_reset();
    s = '{18'h0FFFF, 18'h1FFFE, 18'h2FFFD, 18'h3FFFC, 18'h3FFFC, 18'h3FFFC};
    for (int i = 0; i <= 6; i++) begin
      if (i < 6) drive_cycle(1'b1, s[i], 1'b1, 1'b0);
      else       drive_cycle(1'b0, '0, 1'b1, 1'b0);
      if (i > 0) begin
        checks++;
        if (a_if.valid !== 1'b1 || a_if.data !== 16'hFFFF) begin
          errors++; $display("FAIL wrap_out[%0d]: got v=%b %h expected v=1 ffff", i, a_if.valid, a_if.data);
        end
      end
    end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL wrap_err: got %b expected 0", err); end
  endtask

  task automatic test_backpressure();
    logic       v[10];
    sum_t       d[10];
    logic       r[10];
    logic       ev[10];
    logic [W-1:0] eo[10];
    logic       sr[10];
    do_reset();
    v  = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
    d  = '{18'd1, 18'd3, 18'd6, 18'd6, 18'd6, 18'd6, 18'd10, 18'd14, 18'd0, 18'd0};
    r  = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1};
    ev = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    eo = '{16'd0, 16'd1, 16'd2, 16'd2, 16'd2, 16'd2, 16'd3, 16'd4, 16'd5, 16'd0};
    sr = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1};
    for (int i = 0; i < 10; i++) begin
      drive_cycle(v[i], d[i], r[i], 1'b0);
      checks++;
      if (a_if.valid !== ev[i]) begin errors++; $display("FAIL bp_valid[%0d]: got %b expected %b", i, a_if.valid, ev[i]); end
      if (ev[i]) begin
        checks++;
        if (a_if.data !== eo[i]) begin errors++; $display("FAIL bp_out[%0d]: got %h expected %h", i, a_if.data, eo[i]); end
      end
      checks++;
      if (s_if.ready !== sr[i]) begin errors++; $display("FAIL bp_s_ready[%0d]: got %b expected %b", i, s_if.ready, sr[i]); end
    end
  endtask

  task automatic test_range();
    logic       exp_err;
    logic [7:0] exp_cnt;
    exp_err = CHECK_BUILD;
    exp_cnt = CHECK_BUILD ? 8'd1 : 8'd0;
    do_reset();
    drive_cycle(1'b1, 18'h10000, 1'b1, 1'b0);
    drive_cycle(1'b1, 18'h10001, 1'b1, 1'b0);
    checks++; if (a_if.valid !== 1'b1 || a_if.data !== 16'h0000) begin errors++; $display("FAIL range_out0: got v=%b %h expected v=1 0000", a_if.valid, a_if.data); end
    checks++; if (err !== exp_err) begin errors++; $display("FAIL range_err0: got %b expected %b", err, exp_err); end
    checks++; if (err_cnt !== exp_cnt) begin errors++; $display("FAIL range_cnt0: got %0d expected %0d", err_cnt, exp_cnt); end
    drive_cycle(1'b0, '0, 1'b1, 1'b1);  // clear must not touch err/err_cnt
    checks++; if (a_if.valid !== 1'b1 || a_if.data !== 16'h0001) begin errors++; $display("FAIL range_out1: got v=%b %h expected v=1 0001", a_if.valid, a_if.data); end
    checks++; if (err !== exp_err) begin errors++; $display("FAIL range_err1: got %b expected %b", err, exp_err); end
    checks++; if (err_cnt !== exp_cnt) begin errors++; $display("FAIL range_cnt1: got %0d expected %0d", err_cnt, exp_cnt); end
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
    checks++; if (err !== exp_err || err_cnt !== exp_cnt) begin errors++; $display("FAIL range_after_clear: got %b/%0d expected %b/%0d", err, err_cnt, exp_err, exp_cnt); end
    do_reset();
    checks++; if (err !== 1'b0 || err_cnt !== 8'd0) begin errors++; $display("FAIL range_reset: got %b/%0d expected 0/0", err, err_cnt); end
`ifdef FIR4DEC_CHECK_EN
    // With clear every cycle each sum is reconstructed alone, so every one errs.
    for (int i = 0; i < 260; i++) drive_cycle(1'b1, 18'h10000, 1'b1, 1'b1);
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
    checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL range_saturate: got %0d expected 255", err_cnt); end
    checks++; if (state_dbg !== ERR) begin errors++; $display("FAIL range_state: got %0d expected ERR", state_dbg); end
`endif
  endtask

  task automatic test_flush();
    logic       v[6];
    sum_t       d[6];
    logic       c[6];
    logic       ev[6];
    logic [W-1:0] eo[6];
    do_reset();
    v  = '{1, 1, 1, 0, 1, 0};
    d  = '{18'd1, 18'd3, 18'd6, 18'd0, 18'd4, 18'd0};
    c  = '{0, 0, 0, 1, 0, 0};
    ev = '{0, 1, 1, 1, 0, 1};
    eo = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd0, 16'd4};
    for (int i = 0; i < 6; i++) begin
      drive_cycle(v[i], d[i], 1'b1, c[i]);
      checks++;
      if (a_if.valid !== ev[i] || (ev[i] && a_if.data !== eo[i])) begin
        errors++; $display("FAIL flush_out[%0d]: got v=%b %h expected v=%b %h", i, a_if.valid, a_if.data, ev[i], eo[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive_cycle(1'b1, 18'd1, 1'b0, 1'b0);
    drive_cycle(1'b0, '0, 1'b0, 1'b0);
    checks++; if (a_if.valid !== 1'b1 || a_if.data !== 16'd1) begin errors++; $display("FAIL mid_pending: got v=%b %h expected v=1 0001", a_if.valid, a_if.data); end
    do_reset();
    checks++; if (a_if.valid !== 1'b0) begin errors++; $display("FAIL mid_a_valid: got %b expected 0", a_if.valid); end
    checks++; if (a_if.data !== '0) begin errors++; $display("FAIL mid_a_out: got %h expected 0", a_if.data); end
    checks++; if (s_if.ready !== 1'b1) begin errors++; $display("FAIL mid_s_ready: got %b expected 1", s_if.ready); end
    test_basic("mid");
  endtask

  // Reference: draw random samples, run them through the forward moving-sum
  // filter, and expect the original samples back in order.
  task automatic test_random();
    logic [W-1:0] win[3];
    logic [W-1:0] a_new;
    logic [W-1:0] exp_v;
    sum_t         s_cur;
    logic         pending;
    logic         do_clear;
    logic         rdy;
    int           k;
    do_reset();
    exp_q.delete();
    win = '{16'd0, 16'd0, 16'd0};
    pending = 1'b0;
    a_new = '0;
    s_cur = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!pending && $urandom_range(0, 3) != 0) begin
        a_new   = sample_t'($urandom);
        s_cur   = sum_t'(a_new) + sum_t'(win[0]) + sum_t'(win[1]) + sum_t'(win[2]);
        pending = 1'b1;
      end
      do_clear = !pending && ($urandom_range(0, 7) == 0);
      rdy      = ($urandom_range(0, 2) != 0);
      drive_cycle(pending, pending ? s_cur : '0, rdy, do_clear);
      checks++;
      if (s_if.ready !== (!a_if.valid || a_if.ready)) begin
        errors++; $display("FAIL rand_s_ready[%0d]: got %b expected %b", cyc, s_if.ready, !a_if.valid || a_if.ready);
      end
      if (a_if.valid && a_if.ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_spurious[%0d]: got %h expected no output", cyc, a_if.data);
        end else begin
          exp_v = exp_q.pop_front();
          if (a_if.data !== exp_v) begin errors++; $display("FAIL rand_out[%0d]: got %h expected %h", cyc, a_if.data, exp_v); end
        end
      end
      if (s_if.valid && s_if.ready) begin
        exp_q.push_back(a_new);
        win[2] = win[1];
        win[1] = win[0];
        win[0] = a_new;
        pending = 1'b0;
      end
      if (do_clear) win = '{16'd0, 16'd0, 16'd0};
    end
    if (pending) begin
      drive_cycle(1'b1, s_cur, 1'b1, 1'b0);
      if (a_if.valid && a_if.ready) begin
        checks++;
        exp_v = exp_q.pop_front();
        if (a_if.data !== exp_v) begin errors++; $display("FAIL rand_out_tail: got %h expected %h", a_if.data, exp_v); end
      end
      if (s_if.valid && s_if.ready) exp_q.push_back(a_new);
    end
    k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      drive_cycle(1'b0, '0, 1'b1, 1'b0);
      if (a_if.valid) begin
        checks++;
        exp_v = exp_q.pop_front();
        if (a_if.data !== exp_v) begin errors++; $display("FAIL rand_drain: got %h expected %h", a_if.data, exp_v); end
      end
      k++;
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_lost: got %0d outputs missing expected 0", exp_q.size()); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rand_err: got %b expected 0", err); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset      = 1'b1;
    clear      = 1'b0;
    s_if.valid = 1'b0;
    s_if.data  = '0;
    a_if.ready = 1'b0;
    test_reset();
    test_basic("basic");
    test_wrap();
    test_backpressure();
    test_range();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
